// File: rtl/key_debounce_onehot.sv
// Four-button synchroniser/debouncer producing a held one-hot code with valid/ack handshake.
// Optional overrun flag output is enabled by defining KEYDB_OVERRUN_EN.
module key_debounce_onehot #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic k0,
  input  logic k1,
  input  logic k2,
  input  logic k3,
  input  logic ack,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic valid,
  output logic key_dn
`ifdef KEYDB_OVERRUN_EN
  ,
  output logic overrun
`endif
);

  typedef enum logic {IDLE, DOWN} state_t;

  state_t           state, state_nx;
  logic [3:0]       s_meta, s, sp, db;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code, code_nx, onehot;
  logic             valid_nx, cap, acc, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= '0;
      s      <= '0;
      sp     <= '0;
    end else begin
      s_meta <= {k3, k2, k1, k0};
      s      <= s_meta;
      sp     <= s;
    end
  end

  // One counter serves all lines: any change on any line restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= '0;
    end else if (s != sp) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(DB_CYCLES)) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(DB_CYCLES - 1)) db <= s;
    end
  end

  always_comb begin
    onehot = 4'b0001;
    if (db[3])      onehot = 4'b1000;
    else if (db[2]) onehot = 4'b0100;
    else if (db[1]) onehot = 4'b0010;
  end

  always_comb begin
    state_nx = state;
    code_nx  = code;
    valid_nx = valid;
    cap      = 1'b0;
    case (state)
      IDLE: if (db != '0) begin
        cap      = 1'b1;
        state_nx = DOWN;
      end
      DOWN: if (db == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    acc  = valid & ack;
    drop = cap & valid & ~ack;
    // A capture coinciding with an accepted ack replaces the old code.
    if (cap && !drop) begin
      code_nx  = onehot;
      valid_nx = 1'b1;
    end else if (acc) begin
      code_nx  = '0;
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      code  <= code_nx;
      valid <= valid_nx;
    end
  end

`ifdef KEYDB_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overrun <= 1'b0;
    else if (acc)  overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign {d3, d2, d1, d0} = code;
  assign key_dn = |db;

endmodule

// File: tb/tb_key_debounce_onehot.sv
// Bench for key_debounce_onehot: vector table, directed corner sequences, random run vs model.
module tb_key_debounce_onehot;

  localparam int DBC = 4;

  logic clk = 1'b0;
  logic rst_n, ack;
  logic [3:0] kv;
  logic k0, k1, k2, k3, d0, d1, d2, d3, valid, key_dn;
`ifdef KEYDB_OVERRUN_EN
  logic overrun;
`endif

  assign {k3, k2, k1, k0} = kv;

  key_debounce_onehot #(.DB_CYCLES(DBC), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .k0(k0), .k1(k1), .k2(k2), .k3(k3), .ack(ack),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .valid(valid), .key_dn(key_dn)
`ifdef KEYDB_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int dut_events = 0;
  logic [3:0] prev_code = '0;
  logic kd_seen, valid_seen;

  // Reference model: raw sample history, accepted level, pending code.
  logic [3:0] hist [DBC+3];
  logic [3:0] m_db, m_code;
  logic       m_valid, m_ovr, m_down;

  function automatic logic [3:0] dcode();
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DBC + 3; i++) hist[i] = '0;
    m_db = '0; m_code = '0; m_valid = 1'b0; m_ovr = 1'b0; m_down = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] db_old, oh;
    logic stable, cap, acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    db_old = m_db;
    for (int i = DBC + 2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = kv;
    // Accept the level seen DBC+1 consecutive times, two samples back (synchroniser delay).
    stable = 1'b1;
    for (int i = 3; i <= DBC + 2; i++) if (hist[i] != hist[2]) stable = 1'b0;
    if (stable) m_db = hist[2];
    oh = '0;
    for (int i = 0; i < 4; i++) if (db_old[i]) oh = 4'(1 << i);
    cap = !m_down && (db_old != 0);
    acc = m_valid && ack;
    if (acc) m_ovr = 1'b0;
    else if (cap && m_valid) m_ovr = 1'b1;
    if (cap && !(m_valid && !ack)) begin
      m_code = oh; m_valid = 1'b1;
    end else if (acc) begin
      m_code = '0; m_valid = 1'b0;
    end
    if (!m_down && db_old != 0) m_down = 1'b1;
    else if (m_down && db_old == 0) m_down = 1'b0;
  endtask

  task automatic compare_all();
    check("model_valid", 32'(valid), 32'(m_valid));
    check("model_code", 32'(dcode()), 32'(m_code));
    check("model_key_dn", 32'(key_dn), 32'(|m_db));
`ifdef KEYDB_OVERRUN_EN
    check("model_overrun", 32'(overrun), 32'(m_ovr));
`endif
    if (dcode() != prev_code && dcode() != 0) dut_events++;
    prev_code = dcode();
    kd_seen = kd_seen | key_dn;
    valid_seen = valid_seen | valid;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input logic [3:0] k, input logic a, input int n);
    kv = k; ack = a;
    for (int i = 0; i < n; i++) tick();
    ack = 1'b0;
  endtask

  typedef struct {
    logic [3:0] k;
    logic       a;
    logic       ev;
    logic [3:0] ed;
    logic       ekd;
  } vec_t;
  vec_t tbl [10];

  initial begin
    // k1 held from edge 0; ack on edge 8.
    for (int i = 0; i < 10; i++) tbl[i] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[6].ekd = 1'b1;
    tbl[7] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1};
    tbl[8] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1};
    tbl[9].ekd = 1'b1;

    rst_n = 1'b0; kv = '0; ack = 1'b0; kd_seen = 1'b0; valid_seen = 1'b0;
    model_reset();
    #1;
    check("reset_valid", 32'(valid), 0);
    check("reset_code", 32'(dcode()), 0);
    check("reset_key_dn", 32'(key_dn), 0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: idle for 20 clocks
    run(4'b0000, 1'b0, 20);
    check("idle_valid_seen", 32'(valid_seen), 0);
    check("idle_key_dn_seen", 32'(kd_seen), 0);

    // 2: table
    for (int i = 0; i < 10; i++) begin
      kv = tbl[i].k; ack = tbl[i].a;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_code", i), 32'(dcode()), 32'(tbl[i].ed));
      check($sformatf("tbl%0d_key_dn", i), 32'(key_dn), 32'(tbl[i].ekd));
    end
    ack = 1'b0;
    run(4'b0000, 1'b0, 10);

    // 3: bounce then steady, then short pulse
    dut_events = 0;
    run(4'b0100, 1'b0, 1); run(4'b0000, 1'b0, 1);
    run(4'b0100, 1'b0, 1); run(4'b0000, 1'b0, 1);
    run(4'b0100, 1'b0, 10);
    check("bounce_code", 32'(dcode()), 32'h4);
    check("bounce_events", 32'(dut_events), 1);
    run(4'b0100, 1'b1, 1);
    run(4'b0000, 1'b0, 10);
    kd_seen = 1'b0; valid_seen = 1'b0;
    run(4'b0001, 1'b0, 3);
    run(4'b0000, 1'b0, 10);
    check("pulse_key_dn", 32'(kd_seen), 0);
    check("pulse_valid", 32'(valid_seen), 0);
    check("pulse_events", 32'(dut_events), 1);

    // 4: chord, then partial release
    run(4'b1010, 1'b0, 10);
    check("chord_code", 32'(dcode()), 32'h8);
    run(4'b1010, 1'b1, 1);
    valid_seen = 1'b0;
    run(4'b0010, 1'b0, 10);
    check("partial_release_valid", 32'(valid_seen), 0);
    check("partial_release_events", 32'(dut_events), 2);
    run(4'b0000, 1'b0, 10);

    // 5: unacked code, second press dropped
    run(4'b0010, 1'b0, 10);
    run(4'b0000, 1'b0, 10);
    run(4'b0001, 1'b0, 10);
    check("drop_valid", 32'(valid), 1);
    check("drop_code", 32'(dcode()), 32'h2);
`ifdef KEYDB_OVERRUN_EN
    check("drop_overrun", 32'(overrun), 1);
`endif
    run(4'b0001, 1'b1, 1);
    check("drop_ack_valid", 32'(valid), 0);
`ifdef KEYDB_OVERRUN_EN
    check("drop_ack_overrun", 32'(overrun), 0);
`endif
    run(4'b0000, 1'b0, 10);
    run(4'b0100, 1'b0, 10);
    check("after_drop_code", 32'(dcode()), 32'h4);
    run(4'b0100, 1'b1, 1);
    run(4'b0000, 1'b0, 10);

    // 6: reset while k2 held
    run(4'b0100, 1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(valid), 0);
    check("midreset_key_dn", 32'(key_dn), 0);
    tick(); tick();
    rst_n = 1'b1;
    run(4'b0100, 1'b0, 7);
    check("postreset_e6_valid", 32'(valid), 0);
    tick();
    check("postreset_e7_valid", 32'(valid), 1);
    check("postreset_e7_code", 32'(dcode()), 32'h4);
    run(4'b0100, 1'b1, 1);
    run(4'b0000, 1'b0, 10);

    // Random run: mostly-held levels with occasional glitches and acks.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) kv = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 7) == 0);
      tick();
    end
    ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
